// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_RD,
        STORE_WR,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane extraction with sign/zero extension, and sub-word store merge.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] store_dat,
    output logic [31:0] load_dat,
    output logic [31:0] merge_dat
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = word >> {lane, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = lane[1] ? word[31:16] : word[15:0];

        load_dat = word;
        case (funct3)
            F3_LB:   load_dat = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_dat = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_dat = {24'h0, byte_sel};
            F3_LHU:  load_dat = {16'h0, half_sel};
            default: load_dat = word;
        endcase

        merge_dat = word;
        case (funct3)
            F3_SB: merge_dat[8*lane +: 8] = store_dat[7:0];
            F3_SH: begin
                if (lane[1]) merge_dat[31:16] = store_dat[15:0];
                else         merge_dat[15:0]  = store_dat[15:0];
            end
            default: merge_dat = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Turns byte-addressed RISC-V loads/stores into word-granular dcache reads/writes.
// Latency: 3 cycles load/SW, 4 cycles SB/SH (read-modify-write), 2 cycles on fault.
// Backpressure: lsu_busywait stalls the pipeline; dc_busywait holds the active state.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lsu_read,
    input  logic                  lsu_write,
    input  logic [2:0]            lsu_funct3,
    input  logic [ADDR_WIDTH-1:0] lsu_address,
    input  logic [31:0]           lsu_writedata,
    output logic [31:0]           lsu_readdata,
    output logic                  lsu_busywait,
    output logic                  lsu_fault,
    output logic                  dc_read,
    output logic                  dc_write,
    output logic [31:0]           dc_address,
    output logic [31:0]           dc_writedata,
    input  logic [31:0]           dc_readdata,
    input  logic                  dc_busywait
);

    lsu_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            f3_q;
    logic [31:0]           wdata_q;
    logic [31:0]           merge_q;
    logic                  fault_q;
    logic                  req, f3_ok, misaligned, req_fault;
    logic [31:0]           load_dat, merge_dat;

    // Store funct3 encodings alias the signed-load ones; only LBU/LHU are load-only.
    always_comb begin
        req = lsu_read | lsu_write;
        f3_ok = 1'b0;
        misaligned = 1'b0;
        case (lsu_funct3)
            F3_LB:           f3_ok = 1'b1;
            F3_LH:           begin f3_ok = 1'b1;     misaligned = lsu_address[0]; end
            F3_LW:           begin f3_ok = 1'b1;     misaligned = |lsu_address[1:0]; end
            F3_LBU:          f3_ok = lsu_read;
            F3_LHU:          begin f3_ok = lsu_read; misaligned = lsu_address[0]; end
            default:         f3_ok = 1'b0;
        endcase
        req_fault = (lsu_read & lsu_write) | ~f3_ok | misaligned;
    end

    always_comb begin
        state_nxt    = state;
        lsu_busywait = 1'b0;
        dc_read      = 1'b0;
        dc_write     = 1'b0;
        case (state)
            IDLE: begin
                lsu_busywait = req;
                if (req) begin
                    if (req_fault)               state_nxt = DONE;
                    else if (lsu_read)           state_nxt = LOAD;
                    else if (lsu_funct3 == F3_SW) state_nxt = STORE_WR;
                    else                         state_nxt = STORE_RD;
                end
            end
            LOAD: begin
                lsu_busywait = 1'b1;
                dc_read      = 1'b1;
                if (!dc_busywait) state_nxt = DONE;
            end
            STORE_RD: begin
                lsu_busywait = 1'b1;
                dc_read      = 1'b1;
                if (!dc_busywait) state_nxt = STORE_WR;
            end
            STORE_WR: begin
                lsu_busywait = 1'b1;
                dc_write     = 1'b1;
                if (!dc_busywait) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            f3_q         <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            fault_q      <= 1'b0;
            lsu_readdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                addr_q  <= lsu_address;
                f3_q    <= lsu_funct3;
                wdata_q <= lsu_writedata;
                fault_q <= req_fault;
            end
            if (state == LOAD && !dc_busywait)     lsu_readdata <= load_dat;
            if (state == STORE_RD && !dc_busywait) merge_q      <= merge_dat;
        end
    end

    lsu_lane_align u_align (
        .funct3    (f3_q),
        .lane      (addr_q[1:0]),
        .word      (dc_readdata),
        .store_dat (wdata_q),
        .load_dat  (load_dat),
        .merge_dat (merge_dat)
    );

    assign lsu_fault    = (state == DONE) & fault_q;
    assign dc_address   = 32'({2'b00, addr_q[ADDR_WIDTH-1:2]});
    assign dc_writedata = (f3_q == F3_SW) ? wdata_q : merge_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed cache model.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        lsu_read, lsu_write;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_address, lsu_writedata;
    logic [31:0] lsu_readdata;
    logic        lsu_busywait, lsu_fault;
    logic        dc_read, dc_write;
    logic [31:0] dc_address, dc_writedata, dc_readdata;
    logic        dc_busywait;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:63];
    int stall_left = 0;
    int rd_hs = 0, wr_hs = 0, rd_cyc = 0, wr_cyc = 0, overlap = 0, unstable = 0;
    logic        prev_rd = 0, prev_wr = 0;
    logic [31:0] prev_addr = 0, prev_wdat = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .lsu_read      (lsu_read),
        .lsu_write     (lsu_write),
        .lsu_funct3    (lsu_funct3),
        .lsu_address   (lsu_address),
        .lsu_writedata (lsu_writedata),
        .lsu_readdata  (lsu_readdata),
        .lsu_busywait  (lsu_busywait),
        .lsu_fault     (lsu_fault),
        .dc_read       (dc_read),
        .dc_write      (dc_write),
        .dc_address    (dc_address),
        .dc_writedata  (dc_writedata),
        .dc_readdata   (dc_readdata),
        .dc_busywait   (dc_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign dc_readdata = mem[dc_address[5:0]];
    assign dc_busywait = (dc_read | dc_write) && (stall_left > 0);

    always @(posedge clock) begin
        if ((dc_read || dc_write) && stall_left > 0) stall_left <= stall_left - 1;
        if (dc_read && !dc_busywait) rd_hs <= rd_hs + 1;
        if (dc_write && !dc_busywait) begin
            mem[dc_address[5:0]] <= dc_writedata;
            wr_hs <= wr_hs + 1;
        end
    end

    always @(negedge clock) begin
        if (dc_read) rd_cyc <= rd_cyc + 1;
        if (dc_write) wr_cyc <= wr_cyc + 1;
        if (dc_read && dc_write) overlap <= overlap + 1;
        if ((dc_read && prev_rd && dc_address != prev_addr) ||
            (dc_write && prev_wr && (dc_address != prev_addr || dc_writedata != prev_wdat)))
            unstable <= unstable + 1;
        prev_rd   <= dc_read;
        prev_wr   <= dc_write;
        prev_addr <= dc_address;
        prev_wdat <= dc_writedata;
    end

    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input int stall,
                              output int bw, output logic flt, output logic [31:0] rdat);
        int n;
        n = 0;
        @(negedge clock);
        stall_left    = stall;
        lsu_read      = rd;
        lsu_write     = wr;
        lsu_funct3    = f3;
        lsu_address   = addr;
        lsu_writedata = wd;
        bw = 0;
        #1;
        while (lsu_busywait && n < 200) begin
            bw++;
            n++;
            @(negedge clock);
            #1;
        end
        flt  = lsu_fault;
        rdat = lsu_readdata;
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL timeout: busywait cycles got %0d, need < 200", n);
        end
        lsu_read  = 1'b0;
        lsu_write = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({dc_read, dc_write, lsu_fault, lsu_busywait} !== 4'b0000) begin
            fails++; $display("FAIL reset_strobes: got %b, need 0000", {dc_read, dc_write, lsu_fault, lsu_busywait});
        end
        tests++;
        if ({lsu_readdata, dc_address, dc_writedata} !== 96'h0) begin
            fails++; $display("FAIL reset_data: got %h, need 0", {lsu_readdata, dc_address, dc_writedata});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_lw();
        int bw; logic flt; logic [31:0] rdat; int rc0;
        mem[4] = 32'hDEADBEEF;
        @(negedge clock);
        lsu_read = 1'b1; lsu_funct3 = 3'b010; lsu_address = 32'h10;
        @(negedge clock); #1;
        tests++;
        if (dc_read !== 1'b1 || dc_address !== 32'h4) begin
            fails++; $display("FAIL lw_strobe: got rd=%b addr=%h, need rd=1 addr=00000004", dc_read, dc_address);
        end
        lsu_read = 1'b0;
        @(negedge clock);
        rc0 = rd_hs;
        run_access(1, 0, 3'b010, 32'h10, 0, 0, bw, flt, rdat);
        tests++;
        if (rdat !== 32'hDEADBEEF || bw != 2 || flt !== 1'b0 || rd_hs - rc0 != 1) begin
            fails++; $display("FAIL lw_data: got %h bw=%0d flt=%b hs=%0d, need deadbeef bw=2 flt=0 hs=1", rdat, bw, flt, rd_hs - rc0);
        end
    endtask

    task automatic test_sub_loads();
        int bw; logic flt; logic [31:0] rdat;
        mem[4] = 32'h123480FF;
        run_access(1, 0, 3'b000, 32'h11, 0, 0, bw, flt, rdat);
        tests++;
        if (rdat !== 32'hFFFFFF80 || bw != 2) begin
            fails++; $display("FAIL lb: got %h bw=%0d, need ffffff80 bw=2", rdat, bw);
        end
        run_access(1, 0, 3'b100, 32'h11, 0, 0, bw, flt, rdat);
        tests++;
        if (rdat !== 32'h00000080) begin
            fails++; $display("FAIL lbu: got %h, need 00000080", rdat);
        end
        run_access(1, 0, 3'b001, 32'h12, 0, 0, bw, flt, rdat);
        tests++;
        if (rdat !== 32'h00001234) begin
            fails++; $display("FAIL lh: got %h, need 00001234", rdat);
        end
        run_access(1, 0, 3'b101, 32'h10, 0, 0, bw, flt, rdat);
        tests++;
        if (rdat !== 32'h000080FF) begin
            fails++; $display("FAIL lhu: got %h, need 000080ff", rdat);
        end
        run_access(1, 0, 3'b001, 32'h10, 0, 0, bw, flt, rdat);
        tests++;
        if (rdat !== 32'hFFFF80FF) begin
            fails++; $display("FAIL lh_neg: got %h, need ffff80ff", rdat);
        end
    endtask

    task automatic test_sub_stores();
        int bw; logic flt; logic [31:0] rdat; int r0, w0;
        mem[8] = 32'hAABBCCDD;
        r0 = rd_hs; w0 = wr_hs;
        run_access(0, 1, 3'b000, 32'h22, 32'h11, 0, bw, flt, rdat);
        tests++;
        if (mem[8] !== 32'hAA11CCDD || rd_hs - r0 != 1 || wr_hs - w0 != 1 || bw != 3) begin
            fails++; $display("FAIL sb: got %h rd=%0d wr=%0d bw=%0d, need aa11ccdd rd=1 wr=1 bw=3",
                              mem[8], rd_hs - r0, wr_hs - w0, bw);
        end
        mem[8] = 32'hAABBCCDD;
        run_access(0, 1, 3'b001, 32'h20, 32'h1234BEEF, 0, bw, flt, rdat);
        tests++;
        if (mem[8] !== 32'hAABBBEEF || bw != 3) begin
            fails++; $display("FAIL sh: got %h bw=%0d, need aabbbeef bw=3", mem[8], bw);
        end
        r0 = rd_hs; w0 = wr_hs;
        run_access(0, 1, 3'b010, 32'h24, 32'hCAFEF00D, 0, bw, flt, rdat);
        tests++;
        if (mem[9] !== 32'hCAFEF00D || rd_hs != r0 || wr_hs - w0 != 1 || bw != 2) begin
            fails++; $display("FAIL sw: got %h rd=%0d wr=%0d bw=%0d, need cafef00d rd=0 wr=1 bw=2",
                              mem[9], rd_hs - r0, wr_hs - w0, bw);
        end
    endtask

    task automatic test_faults();
        int bw; logic flt; logic [31:0] rdat; int c0;
        logic [1:0]  v_rw [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
        logic [2:0]  v_f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] v_ad [4] = '{32'h02, 32'h01, 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            c0 = rd_cyc + wr_cyc;
            run_access(v_rw[i][1], v_rw[i][0], v_f3[i], v_ad[i], 0, 0, bw, flt, rdat);
            tests++;
            if (flt !== 1'b1 || bw != 1 || rd_cyc + wr_cyc != c0) begin
                fails++; $display("FAIL fault_%0d: got flt=%b bw=%0d strobes=%0d, need flt=1 bw=1 strobes=0",
                                  i, flt, bw, rd_cyc + wr_cyc - c0);
            end
            @(negedge clock); #1;
            tests++;
            if (lsu_fault !== 1'b0) begin
                fails++; $display("FAIL fault_clear_%0d: got %b, need 0", i, lsu_fault);
            end
        end
    endtask

    task automatic test_miss();
        int bw; logic flt; logic [31:0] rdat; int c0, u0;
        mem[5] = 32'h0BADF00D;
        c0 = rd_cyc; u0 = unstable;
        run_access(1, 0, 3'b010, 32'h14, 0, 20, bw, flt, rdat);
        tests++;
        if (rdat !== 32'h0BADF00D || bw != 22 || rd_cyc - c0 != 21 || unstable != u0) begin
            fails++; $display("FAIL miss: got %h bw=%0d rdcyc=%0d unstable=%0d, need 0badf00d bw=22 rdcyc=21 unstable=0",
                              rdat, bw, rd_cyc - c0, unstable - u0);
        end
    endtask

    task automatic test_reset_mid_access();
        int bw; logic flt; logic [31:0] rdat; int w0;
        mem[8] = 32'hAABBCCDD;
        w0 = wr_cyc;
        @(negedge clock);
        stall_left = 50;
        lsu_write = 1'b1; lsu_funct3 = 3'b000; lsu_address = 32'h22; lsu_writedata = 32'h11;
        @(negedge clock); #1;
        lsu_write = 1'b0;
        tests++;
        if (dc_read !== 1'b1) begin
            fails++; $display("FAIL rst_pre: dc_read got %b, need 1", dc_read);
        end
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({dc_read, dc_write, lsu_fault, lsu_busywait} !== 4'b0000 ||
            {lsu_readdata, dc_address, dc_writedata} !== 96'h0) begin
            fails++; $display("FAIL rst_mid: got strobes=%b data=%h, need 0", {dc_read, dc_write, lsu_fault, lsu_busywait},
                              {lsu_readdata, dc_address, dc_writedata});
        end
        @(negedge clock);
        stall_left = 0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (wr_cyc != w0 || mem[8] !== 32'hAABBCCDD) begin
            fails++; $display("FAIL rst_nowrite: got wr=%0d mem=%h, need wr=0 mem=aabbccdd", wr_cyc - w0, mem[8]);
        end
        run_access(1, 0, 3'b010, 32'h20, 0, 0, bw, flt, rdat);
        tests++;
        if (rdat !== 32'hAABBCCDD || bw != 2) begin
            fails++; $display("FAIL rst_after: got %h bw=%0d, need aabbccdd bw=2", rdat, bw);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset = 1'b0;
        lsu_read = 1'b0; lsu_write = 1'b0; lsu_funct3 = 3'b0;
        lsu_address = 32'h0; lsu_writedata = 32'h0;
        test_reset();
        test_lw();
        test_sub_loads();
        test_sub_stores();
        test_faults();
        test_miss();
        test_reset_mid_access();
        tests++;
        if (overlap != 0 || unstable != 0) begin
            fails++; $display("FAIL protocol: got overlap=%0d unstable=%0d, need 0 0", overlap, unstable);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
